lieat_exu_wbck_arb: RTL

- Writeback-port arbiter that shares the single integer-regfile write port among NREQ execution units (com, lsu, muldiv, vpu, fpu).
- Uses fixed priority, with the highest index winning, plus per-requester anti-starvation aging.
- Registers the winner into a one-entry output stage with a valid/ready handshake toward the regfile/commit logic.
- Sits between the EXU functional-unit outputs and the regfile write/commit path.

---
 rtl/lieat_exu_wbck_arb.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lieat_exu_wbck_arb.sv
// ----------------------------------------------------------------------------
// lieat_exu_wbck_arb
//
// Shares the single integer-regfile write port among NREQ execution units.
// Base priority is fixed, and the highest index wins. Each requester has an
// aging counter. A requester that is denied STARVE_LIM times in a row while
// the output slot was free is promoted. Promoted requesters beat every
// non-promoted one, and among themselves the lowest index goes first. The
// winner is registered into a one-entry output stage that is drained with a
// valid/ready handshake.
//
// Ports
//   clock      : clock, rising edge
//   reset      : asynchronous, active-low reset
//   req_valid  : per-requester writeback request
//   req_ready  : per-requester grant (transfer on req_valid & req_ready)
//   req_en     : per-requester regfile write enable
//   req_rd     : packed destination indices, requester i at [i*REG_IDX +: REG_IDX]
//   req_data   : packed write data,          requester i at [i*XLEN +: XLEN]
//   req_pc     : packed instruction pc,      requester i at [i*XLEN +: XLEN]
//   out_valid  : output stage holds a writeback
//   out_ready  : consumer accepts the output stage
//   out_src    : one-hot source of the held writeback
//   out_en/rd/data/pc : payload of the held writeback
//   starve_o   : a promoted (starving) requester won the current grant
// ----------------------------------------------------------------------------
module lieat_exu_wbck_arb #(
    parameter int NREQ       = 5,
    parameter int XLEN       = 32,
    parameter int REG_IDX    = 5,
    parameter int STARVE_LIM = 7
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ-1:0]         req_en,
    input  logic [NREQ*REG_IDX-1:0] req_rd,
    input  logic [NREQ*XLEN-1:0]    req_data,
    input  logic [NREQ*XLEN-1:0]    req_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NREQ-1:0]         out_src,
    output logic                    out_en,
    output logic [REG_IDX-1:0]      out_rd,
    output logic [XLEN-1:0]         out_data,
    output logic [XLEN-1:0]         out_pc,
    output logic                    starve_o
);

    localparam int CW = $clog2(STARVE_LIM + 1);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    logic                accept;
    logic [NREQ-1:0]     starve;
    logic [NREQ-1:0]     grant;
    logic [IW-1:0]       grant_idx;
    logic                grant_any;
    logic                load;

    logic                out_valid_q, out_valid_d;
    logic [NREQ-1:0]     out_src_q,   out_src_d;
    logic                out_en_q,    out_en_d;
    logic [REG_IDX-1:0]  out_rd_q,    out_rd_d;
    logic [XLEN-1:0]     out_data_q,  out_data_d;
    logic [XLEN-1:0]     out_pc_q,    out_pc_d;

    // The slot can take a new writeback when it is empty or being drained now.
    // This is the only combinational path from out_ready to req_ready.
    assign accept = ~out_valid_q | out_ready;

    // Per-requester aging counters
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_age
        logic [CW-1:0] cnt_q, cnt_d;

        assign starve[gi] = req_valid[gi] & (cnt_q == LIM);

        // Only denials while the slot was free count toward starvation. A
        // stalled output holds the count, because nobody could have won.
        always_comb begin
            cnt_d = cnt_q;
            if (!req_valid[gi] || req_ready[gi]) begin
                cnt_d = '0;
            end else if (accept && (cnt_q != LIM)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // Winner selection. Starving requesters are served lowest-index first so
    // that several of them drain in a fixed order. Otherwise the highest index
    // wins. The descending scan keeps the last (lowest) hit. The ascending
    // scan keeps the last (highest) hit.
    always_comb begin
        grant_idx = '0;
        grant_any = |req_valid;
        if (|starve) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (starve[i]) begin
                    grant_idx = IW'(i);
                end
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i]) begin
                    grant_idx = IW'(i);
                end
            end
        end
        grant = '0;
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign req_ready = grant & {NREQ{accept}};
    assign load      = |req_ready;
    assign starve_o  = accept & (|starve);

    // Output stage. A drain leaves the payload untouched. Only out_valid drops.
    always_comb begin
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        out_en_d    = out_en_q;
        out_rd_d    = out_rd_q;
        out_data_d  = out_data_q;
        out_pc_d    = out_pc_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_src_d   = grant;
            out_en_d    = req_en[grant_idx];
            out_rd_d    = req_rd[int'(grant_idx) * REG_IDX +: REG_IDX];
            out_data_d  = req_data[int'(grant_idx) * XLEN +: XLEN];
            out_pc_d    = req_pc[int'(grant_idx) * XLEN +: XLEN];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            out_en_q    <= 1'b0;
            out_rd_q    <= '0;
            out_data_q  <= '0;
            out_pc_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            out_en_q    <= out_en_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;
    assign out_en    = out_en_q;
    assign out_rd    = out_rd_q;
    assign out_data  = out_data_q;
    assign out_pc    = out_pc_q;

endmodule
